// File: rtl/axil_sram_rd_slave.sv
// axil_sram_rd_slave: AXI4-Lite read-channel (AR/R) responder for a word-addressed SRAM model.
// Accepts one read address at a time, waits a fixed latency, then returns data with OKAY/SLVERR.
// Memory contents are filled through a write-enabled preload port that is active in every state.
// Optional build macro: AXIL_RD_RAND_DELAY_EN adds 0..3 pseudo-random wait cycles per read,
// drawn from a 4-bit LFSR (x^4+x^3+1) that is reset to 4'b1011 and advances on each AR handshake.
module axil_sram_rd_slave #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned LAT    = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              arvalid,
  output logic              arready,
  input  logic [ADDR_W-1:0] araddr,
  output logic              rvalid,
  input  logic              rready,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        rresp,
  input  logic              mem_wen,
  input  logic [ADDR_W-1:0] mem_waddr,
  input  logic [DATA_W-1:0] mem_wdata
);

  localparam int unsigned IDX_W  = ADDR_W - 2;
  localparam int unsigned MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Wide enough for LAT-1 (max 14) plus up to 3 random extra cycles
  localparam int unsigned CNT_W  = 5;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                arready_q;
  logic                rvalid_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [1:0]          rresp_q;

  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                hs_c;
  logic [IDX_W-1:0]    rd_idx_c;
  logic [IDX_W-1:0]    wr_idx_c;
  logic                rd_err_c;
  logic                wr_ok_c;
  logic [DATA_W-1:0]   rd_word_c;
  logic [CNT_W-1:0]    cnt_load_c;
  logic                unused_c;

  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;

  // AR handshake can only happen in IDLE, the only state with arready high
  assign hs_c = arvalid && arready_q;

  // Read decode from the captured address: misaligned or beyond the array is an error
  assign rd_idx_c  = addr_q[ADDR_W-1:2];
  assign rd_err_c  = (addr_q[1:0] != 2'b00) || (64'(rd_idx_c) >= 64'(DEPTH));
  assign rd_word_c = mem_q[MEM_AW'(rd_idx_c)];

  // Preload decode: byte-offset bits are ignored, out-of-range writes are dropped
  assign wr_idx_c = mem_waddr[ADDR_W-1:2];
  assign wr_ok_c  = 64'(wr_idx_c) < 64'(DEPTH);
  assign unused_c = ^mem_waddr[1:0];

`ifdef AXIL_RD_RAND_DELAY_EN
  logic [3:0] lfsr_q;

  assign cnt_load_c = CNT_W'(LAT - 1) + CNT_W'(lfsr_q[1:0]);

  // Delay LFSR: steps once per accepted read address, deterministic from reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      lfsr_q <= 4'b1011;
    end else if (hs_c) begin
      lfsr_q <= {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
    end
  end
`else
  assign cnt_load_c = CNT_W'(LAT - 1);
`endif

  // Preload port; array has no reset and the read capture sees the pre-write word
  always_ff @(posedge clk) begin
    if (mem_wen && wr_ok_c) begin
      mem_q[MEM_AW'(wr_idx_c)] <= mem_wdata;
    end
  end

  // Read transaction FSM with registered AR/R channel outputs
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (hs_c) begin
            addr_q    <= araddr;
            cnt_q     <= cnt_load_c;
            arready_q <= 1'b0;
            state_q   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_q == '0) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_err_c ? '0 : rd_word_c;
            rresp_q  <= rd_err_c ? RESP_SLVERR : RESP_OKAY;
            state_q  <= S_RESP;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_RESP: begin
          if (rready) begin
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
            state_q   <= S_IDLE;
          end
        end
        default: begin
          rvalid_q  <= 1'b0;
          arready_q <= 1'b1;
          state_q   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axil_sram_rd_slave.sv
// tb_axil_sram_rd_slave: randomized read traffic against two instances (LAT=1 and LAT=3)
// sharing the preload port, checked against an array-based memory/latency model.
module tb_axil_sram_rd_slave;

  localparam int unsigned DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [1:0]  arvalid_v = 2'b00;
  logic [31:0] araddr = '0;
  logic        rready = 1'b0;
  logic        mem_wen = 1'b0;
  logic [31:0] mem_waddr = '0;
  logic [31:0] mem_wdata = '0;

  logic        arready0, arready1, rvalid0, rvalid1;
  logic [31:0] rdata0, rdata1;
  logic [1:0]  rresp0, rresp1;

  int          sel = 0;
  logic        cur_arready, cur_rvalid;
  logic [31:0] cur_rdata;
  logic [1:0]  cur_rresp;

  int checks = 0;
  int errors = 0;

  logic [31:0] mdl_mem [DEPTH];
  int          lfsr_m [2];

  always #5 clk = ~clk;

  axil_sram_rd_slave #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .LAT(1)) u_dut_l1 (
    .clk(clk), .rstn(rstn),
    .arvalid(arvalid_v[0]), .arready(arready0), .araddr(araddr),
    .rvalid(rvalid0), .rready(rready), .rdata(rdata0), .rresp(rresp0),
    .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
  );

  axil_sram_rd_slave #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .LAT(3)) u_dut_l3 (
    .clk(clk), .rstn(rstn),
    .arvalid(arvalid_v[1]), .arready(arready1), .araddr(araddr),
    .rvalid(rvalid1), .rready(rready), .rdata(rdata1), .rresp(rresp1),
    .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
  );

  // Observe whichever instance the current transaction targets
  always_comb begin
    cur_arready = (sel == 1) ? arready1 : arready0;
    cur_rvalid  = (sel == 1) ? rvalid1  : rvalid0;
    cur_rdata   = (sel == 1) ? rdata1   : rdata0;
    cur_rresp   = (sel == 1) ? rresp1   : rresp0;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void model_rd(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
    if (a[1:0] != 2'b00 || (a >> 2) >= 32'(DEPTH)) begin
      d = '0;
      r = 2'b10;
    end else begin
      d = mdl_mem[int'(a >> 2)];
      r = 2'b00;
    end
  endfunction

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    mem_wen = 1'b1; mem_waddr = a; mem_wdata = d;
    @(negedge clk);
    mem_wen = 1'b0;
    if ((a >> 2) < 32'(DEPTH)) mdl_mem[int'(a >> 2)] = d;
  endtask

  task automatic do_reset_checked();
    @(negedge clk);
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    lfsr_m[0] = 11;
    lfsr_m[1] = 11;
    for (int s = 0; s < 2; s++) begin
      sel = s;
      #0;
      chk("rst_arready", cur_arready, 1);
      chk("rst_rvalid", cur_rvalid, 0);
      chk("rst_rdata", cur_rdata, 0);
      chk("rst_rresp", cur_rresp, 0);
    end
  endtask

  // One read on instance s; wr_mode 1 writes the same word on the capture edge,
  // wr_mode 2 writes it one edge earlier
  task automatic do_read(input int s, input logic [31:0] a, input int bp,
                         input int wr_mode, input logic [31:0] wr_d);
    logic [31:0] ed;
    logic [1:0]  er;
    int          el;
    int          wr_at;
    int          n;
    model_rd(a, ed, er);
    el = (s == 1) ? 3 : 1;
`ifdef AXIL_RD_RAND_DELAY_EN
    el += lfsr_m[s] % 4;
    lfsr_m[s] = ((lfsr_m[s] * 2) % 16) + (((lfsr_m[s] / 8) + (lfsr_m[s] / 4)) % 2);
`endif
    wr_at = -1;
    if (wr_mode == 1) wr_at = el - 1;
    if (wr_mode == 2 && el >= 2) wr_at = el - 2;
    if (wr_at >= 0 && wr_at < el - 1 && er == 2'b00) ed = wr_d;
    sel = s;
    @(negedge clk);
    arvalid_v[s] = 1'b1; araddr = a; rready = 1'b0;
    n = 0;
    while (!cur_arready && n < 20) begin @(negedge clk); n++; end
    chk("ar_ready_idle", cur_arready, 1);
    @(negedge clk);
    arvalid_v[s] = 1'b0;
    chk("ar_busy", cur_arready, 0);
    n = 0;
    while (!cur_rvalid && n < 40) begin
      if (n == wr_at) begin mem_wen = 1'b1; mem_waddr = a; mem_wdata = wr_d; end
      @(negedge clk);
      mem_wen = 1'b0;
      n++;
    end
    if (wr_at >= 0 && wr_at < el) mdl_mem[int'(a >> 2)] = wr_d;
    chk("latency", n, el);
    chk("rdata", cur_rdata, ed);
    chk("rresp", cur_rresp, er);
    for (int i = 0; i < bp; i++) begin
      arvalid_v[s] = 1'b1;
      araddr = $urandom;
      @(negedge clk);
      chk("bp_rvalid", cur_rvalid, 1);
      chk("bp_rdata", cur_rdata, ed);
      chk("bp_rresp", cur_rresp, er);
      chk("bp_arready", cur_arready, 0);
    end
    arvalid_v[s] = 1'b0;
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    chk("r_done_rvalid", cur_rvalid, 0);
    chk("r_done_arready", cur_arready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    int          s;
    int          k;
    int          wm;

    for (int i = 0; i < int'(DEPTH); i++) mdl_mem[i] = '0;
    do_reset_checked();

    // Fill the region the traffic uses, the last word, and the directed word
    for (int i = 0; i < 64; i++) preload(32'(i) << 2, $urandom);
    preload(32'((DEPTH - 1) * 4), 32'hCAFE_F00D);
    preload(32'h10, 32'hDEAD_BEEF);
    preload(32'((DEPTH + 5) * 4), 32'h1234_5678);

    do_read(0, 32'h10, 0, 0, 0);
    do_read(0, 32'h14, 5, 0, 0);
    do_read(1, 32'h10, 5, 0, 0);
    do_read(0, 32'h12, 0, 0, 0);
    do_read(0, 32'(DEPTH * 4), 1, 0, 0);
    do_read(1, 32'h13, 0, 0, 0);
    do_read(1, 32'((DEPTH - 1) * 4), 0, 0, 0);
    do_read(0, 32'((DEPTH + 5) * 4), 0, 0, 0);

    // Collision at the capture edge returns the old word, later read sees the new one
    do_read(1, 32'h20, 0, 1, 32'hA5A5_0001);
    do_read(1, 32'h20, 0, 0, 0);
    do_read(0, 32'h24, 0, 1, 32'hA5A5_0002);
    do_read(0, 32'h24, 0, 0, 0);
    do_read(1, 32'h28, 0, 2, 32'hA5A5_0003);

    // Reset while the LAT=3 instance is waiting: no beat, back to accepting
    sel = 1;
    @(negedge clk);
    arvalid_v[1] = 1'b1; araddr = 32'h30;
    @(negedge clk);
    arvalid_v[1] = 1'b0;
    chk("midwait_busy", cur_arready, 0);
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    lfsr_m[0] = 11;
    lfsr_m[1] = 11;
    for (int i = 0; i < 6; i++) begin
      chk("midwait_no_rvalid", cur_rvalid, 0);
      @(negedge clk);
    end
    chk("midwait_arready", cur_arready, 1);

    for (int i = 0; i < 40; i++) begin
      s = int'($urandom_range(0, 1));
      k = int'($urandom_range(0, 9));
      wm = 0;
      if (k < 6) begin
        a = 32'($urandom_range(0, 63)) << 2;
        wm = int'($urandom_range(0, 2));
      end else if (k == 6) begin
        a = 32'((DEPTH - 1) * 4);
      end else if (k == 7) begin
        a = (32'($urandom_range(0, 255)) << 2) + 32'($urandom_range(1, 3));
      end else begin
        a = 32'(DEPTH * 4) + (32'($urandom_range(0, 4095)) << 2);
      end
      if ($urandom_range(0, 3) == 0) preload(32'($urandom_range(0, 63)) << 2, $urandom);
      do_read(s, a, int'($urandom_range(0, 3)), wm, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
